// File: rtl/apexii_ddio_out_tx.sv
// DDIO transmit buffer: a FIFO of high/low word pairs drained onto the DDIO output registers,
// with a programmable oe lead/tail window. Define APEXII_DDIO_OUT_STATS_EN to add words_sent.
module apexii_ddio_out_tx #(
    parameter int              WIDTH      = 8,
    parameter int              DEPTH      = 4,
    parameter int              OE_LEAD    = 1,
    parameter int              OE_TAIL    = 1,
    parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             clkena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data_h,
    input  logic [WIDTH-1:0] in_data_l,
    output logic [WIDTH-1:0] ddio_h,
    output logic [WIDTH-1:0] ddio_l,
    output logic             oe,
    output logic             busy
`ifdef APEXII_DDIO_OUT_STATS_EN
    ,
    output logic [15:0]      words_sent
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [3:0]    LEAD_LAST = (OE_LEAD > 0) ? 4'(OE_LEAD - 1) : 4'd0;
    localparam logic [3:0]    TAIL_LAST = (OE_TAIL > 0) ? 4'(OE_TAIL - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_DATA, S_TAIL} state_t;

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               oe_q, oe_d;
    logic [WIDTH-1:0]   h_q, h_d, l_q, l_d;
    logic               push, pop, empty;
    logic [2*WIDTH-1:0] head;

    // Full is judged on the registered count, so a pop at full never frees a same-edge push.
    assign in_ready = (count_q != FULL);
    assign push     = in_valid && in_ready;
    assign empty    = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_data_h, in_data_l};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oe_d    = oe_q;
        h_d     = h_q;
        l_d     = l_q;
        pop     = 1'b0;
        if (clkena) begin
            unique case (state_q)
                S_IDLE: if (!empty) begin
                    oe_d = 1'b1;
                    if (OE_LEAD == 0) begin
                        state_d = S_DATA;
                        pop     = 1'b1;
                    end else begin
                        state_d = S_LEAD;
                        cnt_d   = 4'd0;
                    end
                end
                S_LEAD: if (cnt_q == LEAD_LAST) begin
                    state_d = S_DATA;
                    pop     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
                S_DATA: if (!empty) begin
                    pop = 1'b1;
                end else begin
                    h_d = IDLE_VALUE;
                    l_d = IDLE_VALUE;
                    if (OE_TAIL == 0) begin
                        state_d = S_IDLE;
                        oe_d    = 1'b0;
                    end else begin
                        state_d = S_TAIL;
                        cnt_d   = 4'd0;
                    end
                end
                S_TAIL: if (!empty) begin
                    state_d = S_DATA;
                    pop     = 1'b1;
                end else if (cnt_q == TAIL_LAST) begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (pop) {h_d, l_d} = head;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            oe_q     <= 1'b0;
            h_q      <= IDLE_VALUE;
            l_q      <= IDLE_VALUE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            oe_q     <= oe_d;
            h_q      <= h_d;
            l_q      <= l_d;
        end
    end

    assign ddio_h = h_q;
    assign ddio_l = l_q;
    assign oe     = oe_q;
    assign busy   = (state_q != S_IDLE) || !empty;

`ifdef APEXII_DDIO_OUT_STATS_EN
    logic [15:0] words_sent_q, words_sent_d;

    always_comb begin
        words_sent_d = words_sent_q;
        if (pop && words_sent_q != 16'hFFFF) words_sent_d = words_sent_q + 16'd1;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) words_sent_q <= 16'd0;
        else           words_sent_q <= words_sent_d;
    end

    assign words_sent = words_sent_q;
`endif

endmodule

// File: tb/tb_apexii_ddio_out_tx.sv
// Self-checking bench for apexii_ddio_out_tx: scenario tasks compared against a queue-based
// behavioural model of the oe window and word stream.
module tb_apexii_ddio_out_tx;
    localparam int D = 4;
    localparam int L = 1;
    localparam int T = 1;
    localparam logic [7:0] IDLE = 8'h00;

    logic       clk = 1'b0;
    logic       areset_n, clkena, in_valid, in_ready, oe, busy;
    logic [7:0] in_data_h, in_data_l, ddio_h, ddio_l;
`ifdef APEXII_DDIO_OUT_STATS_EN
    logic [15:0] words_sent;
`endif

    int errors = 0;
    int checks = 0;

    apexii_ddio_out_tx dut (
        .clk(clk), .areset_n(areset_n), .clkena(clkena),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data_h(in_data_h), .in_data_l(in_data_l),
        .ddio_h(ddio_h), .ddio_l(ddio_l), .oe(oe), .busy(busy)
`ifdef APEXII_DDIO_OUT_STATS_EN
        , .words_sent(words_sent)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: pending words in a queue, lead/tail as countdowns of enabled edges.
    logic [7:0]  mq_h[$], mq_l[$];
    bit          m_oe = 0, m_pres = 0;
    int          m_lead = 0, m_tail = 0, m_pops = 0;
    logic [7:0]  m_h = IDLE, m_l = IDLE;
    logic [15:0] m_sent = 0;

    task automatic model_clear();
        mq_h.delete(); mq_l.delete();
        m_oe = 0; m_pres = 0; m_lead = 0; m_tail = 0;
        m_h = IDLE; m_l = IDLE; m_sent = 0;
    endtask

    task automatic model_present();
        m_h = mq_h.pop_front();
        m_l = mq_l.pop_front();
        m_pres = 1;
        m_pops++;
        if (m_sent != 16'hFFFF) m_sent++;
    endtask

    task automatic model_edge();
        bit avail, rdy;
        avail = mq_h.size() != 0;
        rdy   = mq_h.size() != D;
        if (clkena) begin
            if (!m_oe) begin
                if (avail) begin
                    m_oe = 1;
                    if (L == 0) model_present(); else m_lead = L;
                end
            end else if (m_lead > 0) begin
                m_lead--;
                if (m_lead == 0) model_present();
            end else if (avail) begin
                model_present();
            end else if (m_pres) begin
                m_pres = 0; m_h = IDLE; m_l = IDLE;
                if (T == 0) m_oe = 0; else m_tail = T;
            end else begin
                m_tail--;
                if (m_tail == 0) m_oe = 0;
            end
        end
        if (in_valid && rdy) begin
            mq_h.push_back(in_data_h);
            mq_l.push_back(in_data_l);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge areset_n);
        if (!areset_n) model_clear(); else model_edge();
    end

    function automatic logic [18:0] dut_vec();
        return {oe, busy, in_ready, ddio_h, ddio_l};
    endfunction

    function automatic logic [18:0] mdl_vec();
        return {m_oe, (m_oe || mq_h.size() != 0), (mq_h.size() != D), m_h, m_l};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_push(input logic [7:0] h, input logic [7:0] l);
        bit acc = 0;
        in_valid = 1; in_data_h = h; in_data_l = l;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 0;
        if (!acc) begin
            errors++;
            $display("FAIL push_timeout got in_ready=0 exp accepted");
        end
    endtask

    task automatic test_reset();
        areset_n = 0; clkena = 1; in_valid = 0; in_data_h = 0; in_data_l = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({oe, busy, in_ready, ddio_h, ddio_l} !== {1'b0, 1'b0, 1'b1, IDLE, IDLE}) begin
            errors++;
            $display("FAIL reset_values got=%h exp=%h", dut_vec(), {1'b0, 1'b0, 1'b1, IDLE, IDLE});
        end
        areset_n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (dut_vec() !== {1'b0, 1'b0, 1'b1, IDLE, IDLE}) begin
                errors++;
                $display("FAIL idle_hold cyc=%0d got=%h exp=%h", i, dut_vec(), {1'b0, 1'b0, 1'b1, IDLE, IDLE});
            end
        end
    endtask

    task automatic test_single();
        int oe_cnt = 0, rise = -1, wcyc = -1;
        in_valid = 1; in_data_h = 8'hA5; in_data_l = 8'h5A;
        tick();
        in_valid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL single_model cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
            if (oe) oe_cnt++;
            if (oe && rise < 0) rise = i;
            if ({ddio_h, ddio_l} == 16'hA55A && wcyc < 0) wcyc = i;
            if (wcyc >= 0 && i == wcyc + 1) begin
                checks++;
                if ({oe, ddio_h, ddio_l} !== {1'b1, IDLE, IDLE}) begin
                    errors++;
                    $display("FAIL single_tail got=%h exp=%h", {oe, ddio_h, ddio_l}, {1'b1, IDLE, IDLE});
                end
            end
        end
        checks++;
        if (oe_cnt != L + 1 + T) begin
            errors++;
            $display("FAIL single_oe_width got=%0d exp=%0d", oe_cnt, L + 1 + T);
        end
        checks++;
        if (rise != 0 || wcyc != 1) begin
            errors++;
            $display("FAIL single_latency got rise=%0d word=%0d exp rise=0 word=1", rise, wcyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words[6], got[$];
        int pushed = 0, oe_cnt = 0, first = -1, last = -1, last_pops = m_pops;
        bit saw_full = 0, acc;
        for (int i = 0; i < 6; i++) words[i] = 16'($urandom);
        for (int c = 0; c < 40; c++) begin
            clkena = (c >= 5);
            in_valid = (pushed < 6);
            if (pushed < 6) {in_data_h, in_data_l} = words[pushed];
            if (!in_ready) saw_full = 1;
            acc = in_valid && in_ready;
            tick();
            if (acc) pushed++;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL b2b_model cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
            end
            if (oe) oe_cnt++;
            if (m_pops != last_pops) begin
                got.push_back({ddio_h, ddio_l});
                last_pops = m_pops;
                if (first < 0) first = c;
                last = c;
            end
        end
        in_valid = 0; clkena = 1;
        checks++;
        if (!saw_full) begin
            errors++;
            $display("FAIL b2b_full got in_ready_low=0 exp 1");
        end
        checks++;
        if (oe_cnt != L + 6 + T || last - first != 5) begin
            errors++;
            $display("FAIL b2b_width got oe=%0d span=%0d exp oe=%0d span=5", oe_cnt, last - first, L + 6 + T);
        end
        checks++;
        if (got.size() != 6) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got[i] !== words[i]) begin
                    errors++;
                    $display("FAIL b2b_word idx=%0d got=%h exp=%h", i, got[i], words[i]);
                end
            end
        end
    endtask

    task automatic test_tail_rejoin();
        int pushed = 0, oe_cnt = 0, rises = 0;
        bit inj = 0, prev_oe = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 0;
            if (pushed < 2) begin
                in_valid = 1; in_data_h = 8'(c + 8'h10); in_data_l = 8'(c + 8'h20);
                pushed++;
            end else if (!inj && m_pres && mq_h.size() == 0) begin
                in_valid = 1; in_data_h = 8'hC3; in_data_l = 8'h3C;
                inj = 1;
            end
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL rejoin_model cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
            end
            if (oe) oe_cnt++;
            if (oe && !prev_oe) rises++;
            prev_oe = oe;
        end
        in_valid = 0;
        checks++;
        if (rises != 1 || oe_cnt != L + 2 + 1 + 1 + T) begin
            errors++;
            $display("FAIL rejoin_oe got rises=%0d width=%0d exp rises=1 width=%0d", rises, oe_cnt, L + 4 + T);
        end
    endtask

    task automatic test_clkena_freeze();
        logic [15:0] words[5], got[$];
        logic [16:0] snap;
        int last_pops = m_pops, n;
        for (int i = 0; i < 5; i++) words[i] = 16'($urandom);
        clkena = 0;
        for (int i = 0; i < 3; i++) drive_push(words[i][15:8], words[i][7:0]);
        clkena = 1;
        for (n = 0; n < 10 && !m_pres; n++) tick();
        if (!m_pres) begin
            errors++;
            $display("FAIL freeze_start_timeout got pres=0 exp 1");
        end
        got.push_back({ddio_h, ddio_l});
        last_pops = m_pops;
        snap = {m_oe, m_h, m_l};
        clkena = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 2);
            if (c < 2) {in_data_h, in_data_l} = words[3 + c];
            tick();
            checks++;
            if ({oe, ddio_h, ddio_l} !== snap || dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL freeze_hold cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
            end
        end
        in_valid = 0; clkena = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL freeze_resume cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
            end
            if (m_pops != last_pops) begin
                got.push_back({ddio_h, ddio_l});
                last_pops = m_pops;
            end
        end
        checks++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL freeze_count got=%0d exp=5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== words[i]) begin
                    errors++;
                    $display("FAIL freeze_word idx=%0d got=%h exp=%h", i, got[i], words[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        clkena = 0;
        for (int i = 0; i < 4; i++) drive_push(8'(8'h40 + i), 8'(8'h80 + i));
        clkena = 1;
        for (int n = 0; n < 10 && !m_pres; n++) tick();
        checks++;
        if (!oe || {ddio_h, ddio_l} !== 16'h4080) begin
            errors++;
            $display("FAIL midrst_pre got oe=%b word=%h exp oe=1 word=4080", oe, {ddio_h, ddio_l});
        end
        #2 areset_n = 0;
        #1;
        checks++;
        if ({oe, busy, in_ready, ddio_h, ddio_l} !== {1'b0, 1'b0, 1'b1, IDLE, IDLE}) begin
            errors++;
            $display("FAIL midrst_async got=%h exp=%h", dut_vec(), {1'b0, 1'b0, 1'b1, IDLE, IDLE});
        end
        @(negedge clk);
        areset_n = 1;
        for (int c = 0; c < 15; c++) begin
            tick();
            checks++;
            if (dut_vec() !== {1'b0, 1'b0, 1'b1, IDLE, IDLE}) begin
                errors++;
                $display("FAIL midrst_stale cyc=%0d got=%h exp=%h", c, dut_vec(), {1'b0, 1'b0, 1'b1, IDLE, IDLE});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                clkena   = ($urandom_range(0, 3) != 0);
                in_valid = $urandom_range(0, 1) == 1;
            end else begin
                clkena = 1; in_valid = 0;
            end
            in_data_h = 8'($urandom); in_data_l = 8'($urandom);
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec());
            end
        end
        in_valid = 0; clkena = 1;
    endtask

`ifdef APEXII_DDIO_OUT_STATS_EN
    task automatic test_stats();
        areset_n = 0;
        @(negedge clk);
        areset_n = 1;
        clkena = 1;
        for (int i = 0; i < 5; i++) drive_push(8'(i), 8'(i));
        repeat (20) tick();
        for (int i = 0; i < 3; i++) drive_push(8'(i), 8'(i));
        repeat (20) tick();
        checks++;
        if (words_sent !== 16'd8 || m_sent != 16'd8) begin
            errors++;
            $display("FAIL stats_count got=%0d exp=8", words_sent);
        end
        force dut.words_sent_q = 16'hFFFE;
        #1 release dut.words_sent_q;
        for (int i = 0; i < 3; i++) drive_push(8'(i), 8'(i));
        repeat (20) tick();
        checks++;
        if (words_sent !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_sat got=%h exp=ffff", words_sent);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_tail_rejoin();
        test_clkena_freeze();
        test_reset_mid();
        test_random();
`ifdef APEXII_DDIO_OUT_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apexii_ddio_out_tx.md
Name: apexii_ddio_out_tx

Overview:
- Transmit-side companion to the DDIO input path: buffers parallel high/low word pairs and drives them onto a DDIO output register pair, one pair per enabled clock.
- Generates the pad output-enable with a programmable lead (preamble) and tail (postamble) window around each burst.
- Sits between core logic (valid/ready source) and the apexii_io output atom (datain_h/datain_l/oe).

Parameters:
- WIDTH, 8, bits per DDIO half-word.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- OE_LEAD, 1, enabled cycles oe is high before the first word of a burst; 0..15.
- OE_TAIL, 1, enabled cycles oe stays high after the last word; 0..15.
- IDLE_VALUE, 0, level driven on ddio_h/ddio_l when no word is presented; WIDTH bits.

Ports:
- clk  in  1  clock.
- areset_n  in  1  asynchronous active-low reset.
- clkena  in  1  advances the FSM, FIFO pop and output registers when high.
- in_valid  in  1  source has a word pair.
- in_ready  out  1  FIFO can accept a word pair.
- in_data_h  in  WIDTH  rising-edge half.
- in_data_l  in  WIDTH  falling-edge half.
- ddio_h  out  WIDTH  to atom datain_h.
- ddio_l  out  WIDTH  to atom datain_l.
- oe  out  1  pad output enable.
- busy  out  1  high when state != IDLE or FIFO is non-empty.

Behaviour:
- Reset (async assert, sync release): FIFO empty, state IDLE, ddio_h=ddio_l=IDLE_VALUE, oe=0, in_ready=1, busy=0.
- Push:
  - in_ready = (count != DEPTH), taken from the registered count.
  - Push on in_valid && in_ready at any edge, independent of clkena.
  - At full, a same-cycle pop does not enable a push.
- Pop happens only on an enabled edge (clkena=1), in DATA entry/continuation as below. Pointers wrap modulo DEPTH.
- All outputs are registered. With clkena=0 the FSM, pop and outputs hold; push continues.
- FSM, evaluated on enabled edges. Lead/tail counters are 4-bit and count enabled edges only.
  - IDLE: if FIFO non-empty, go to LEAD with oe<=1 (OE_LEAD>0). If OE_LEAD=0, go straight to DATA, pop, oe<=1, outputs<=word.
  - LEAD: after OE_LEAD enabled edges in LEAD, go to DATA, pop the head word, outputs<=word.
  - DATA: if FIFO non-empty, pop and present the next word (back-to-back, no gap). If empty, go to TAIL with outputs<=IDLE_VALUE and oe held at 1. If OE_TAIL=0, go straight to IDLE with oe<=0.
  - TAIL: if FIFO non-empty, go to DATA with a pop and no new lead. Otherwise, after OE_TAIL enabled edges go to IDLE with oe<=0.
- Latency with OE_LEAD=1, empty FIFO, clkena=1:
  - push at edge 0;
  - oe=1 after edge 1;
  - first word on ddio_h/ddio_l after edge 2.
- Burst of N words, OE_LEAD=L, OE_TAIL=T: oe is high for exactly L+N+T consecutive enabled cycles.
- Reset asserted mid-burst: immediate return to reset values; FIFO contents are discarded.

Optional Feature:
- Macro: APEXII_DDIO_OUT_STATS_EN.
- Defined: adds output port words_sent (16 bits). It increments on every pop, saturates at 16'hFFFF and clears on reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, clkena=1, no valid -> oe=0, ddio_h=ddio_l=0, in_ready=1, busy=0 held for 20 cycles.
- OE_LEAD=1, OE_TAIL=1, push one pair (h=8'hA5, l=8'h5A) -> oe high for exactly 3 cycles; A5/5A appears the cycle after oe rises; the cycle after, outputs=0 with oe=1.
- Push 6 pairs back-to-back with DEPTH=4 -> in_ready drops at count 4; all 6 words are driven consecutively with no idle gap; total oe width = 1+6+1 = 8 cycles.
- After a burst drains, a new word is pushed during TAIL -> returns to DATA with no lead cycle and oe never drops.
- clkena held low for 5 cycles mid-burst while pushing 2 words -> outputs/oe frozen, pushes accepted; on clkena=1 sequence resumes in order with no loss or duplication.
- areset_n pulsed low during DATA with 3 words queued -> oe=0, outputs=IDLE_VALUE immediately; after release busy=0 and no stale words are emitted.
- With APEXII_DDIO_OUT_STATS_EN: two bursts of 5 and 3 words -> words_sent=8; forced preload 16'hFFFE plus 3 pops -> 16'hFFFF.
